// File: rtl/sr_tff.sv
// SR flip-flop built from a T flip-flop and an S/R-to-T converter; S=R=1 toggles.
// Latency: one clock from S/R to Q. No backpressure; synchronous active-high reset wins over S/R.
module sr_tff (
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Q_bar
);

    logic w_t;
    logic w_q;

    // Toggle only when the requested level differs from the stored one;
    // with both requests high each term covers one state, so the bit always flips.
    assign w_t = (S & ~w_q) | (R & w_q);

    sr_tff_tcore u_tcore (
        .clk (clk),
        .rst (rst),
        .i_t (w_t),
        .o_q (w_q)
    );

    assign Q     = w_q;
    assign Q_bar = ~w_q;

endmodule

// Plain T flip-flop with synchronous active-high clear.
// Latency: one clock from T to Q. No backpressure.
module sr_tff_tcore (
    input  logic clk,
    input  logic rst,
    input  logic i_t,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (i_t) begin
            r_q <= ~r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: tb/tb_sr_tff.sv
// Directed bench for sr_tff: hand-computed Q after each edge, Q_bar checked as its complement.
module tb_sr_tff;

    logic clk;
    logic rst;
    logic S;
    logic R;
    logic Q;
    logic Q_bar;

    int tests;
    int fails;

    sr_tff dut (
        .clk   (clk),
        .rst   (rst),
        .S     (S),
        .R     (R),
        .Q     (Q),
        .Q_bar (Q_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic exp_q);
        logic exp_qb;
        exp_qb = ~exp_q;
        tests++;
        assert (Q === exp_q) else begin
            fails++;
            $error("FAIL %s: Q observed %b expected %b", tag, Q, exp_q);
        end
        tests++;
        assert (Q_bar === exp_qb) else begin
            fails++;
            $error("FAIL %s: Q_bar observed %b expected %b", tag, Q_bar, exp_qb);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic rst_v, input logic s_v,
                        input logic r_v, input logic exp_q);
        @(negedge clk);
        rst = rst_v;
        S   = s_v;
        R   = r_v;
        @(posedge clk);
        #1;
        check(tag, exp_q);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        S   = 1'b0;
        R   = 1'b0;

        step("reset",          1'b1, 1'b0, 1'b0, 1'b0);
        step("idle_after_rst0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle_after_rst1", 1'b0, 1'b0, 1'b0, 1'b0);

        step("clear_from0",    1'b0, 1'b0, 1'b1, 1'b0);
        step("hold0",          1'b0, 1'b0, 1'b0, 1'b0);
        step("set_from0",      1'b0, 1'b1, 1'b0, 1'b1);
        step("hold1",          1'b0, 1'b0, 1'b0, 1'b1);

        step("both_from1",     1'b0, 1'b1, 1'b1, 1'b0);
        step("hold0_b",        1'b0, 1'b0, 1'b0, 1'b0);
        step("toggle_k1",      1'b0, 1'b1, 1'b1, 1'b1);
        step("toggle_k2",      1'b0, 1'b1, 1'b1, 1'b0);
        step("toggle_k3",      1'b0, 1'b1, 1'b1, 1'b1);

        step("set_redundant0", 1'b0, 1'b1, 1'b0, 1'b1);
        step("set_redundant1", 1'b0, 1'b1, 1'b0, 1'b1);
        step("clear_from1",    1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_redundant0", 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr_redundant1", 1'b0, 1'b0, 1'b1, 1'b0);

        step("set_before_rst", 1'b0, 1'b1, 1'b0, 1'b1);
        step("rst_over_set",   1'b1, 1'b1, 1'b0, 1'b0);
        step("set_after_rst",  1'b0, 1'b1, 1'b0, 1'b1);
        step("rst_over_both",  1'b1, 1'b1, 1'b1, 1'b0);

        // S pulses strictly between edges while Q=0; Q must not move.
        @(negedge clk);
        rst = 1'b0;
        S   = 1'b0;
        R   = 1'b0;
        @(posedge clk);
        #2;
        S = 1'b1;
        #3;
        S = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_s", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
